// File: rtl/median_pkg.sv
// Shared types and constants for the median window collector and sort network.
package median_pkg;

    localparam int unsigned MEDIAN_WIN = 10;

    typedef logic [31:0] data_t;
    typedef logic [15:0] seq_t;
    typedef logic [3:0]  need_t;

    typedef enum logic [1:0] {
        StFill,
        StGap,
        StEmit
    } win_state_e;

endpackage

// File: rtl/median_window_ctrl.sv
// Window control: FSM, remaining-accept counter, window sequence number and
// input/output handshake logic. Emits a shift-enable for the lane register.
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int unsigned STRIDE = 1
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_flush,
    input  logic i_in_valid,
    input  logic i_out_ready,
    output logic o_in_ready,
    output logic o_out_valid,
    output logic o_shift_en,
    output seq_t o_out_seq
);

    localparam need_t NEED_FULL      = need_t'(MEDIAN_WIN);
    localparam need_t NEED_STRIDE    = need_t'(STRIDE);
    localparam need_t NEED_STRIDE_M1 = need_t'(STRIDE - 1);

    win_state_e r_state, w_state_d;
    need_t      r_need, w_need_d;
    seq_t       r_seq, w_seq_d;

    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_out_hs;

    assign w_out_valid = (r_state == StEmit);
    // The window is frozen while presented; a new sample may only enter
    // in the same cycle the current window is taken.
    assign w_in_ready  = !w_out_valid || i_out_ready;
    assign w_accept    = i_in_valid && w_in_ready;
    assign w_out_hs    = w_out_valid && i_out_ready;

    always_comb begin
        w_state_d = r_state;
        w_need_d  = r_need;
        w_seq_d   = r_seq;
        if (i_flush) begin
            w_state_d = StFill;
            w_need_d  = NEED_FULL;
            w_seq_d   = '0;
        end else begin
            case (r_state)
                StFill, StGap: begin
                    if (w_accept) begin
                        if (r_need == need_t'(1)) begin
                            w_state_d = StEmit;
                            w_need_d  = '0;
                        end else begin
                            w_need_d = r_need - need_t'(1);
                        end
                    end
                end
                StEmit: begin
                    if (w_out_hs) begin
                        w_seq_d = r_seq + seq_t'(1);
                        if (w_accept && (STRIDE == 1)) begin
                            w_state_d = StEmit;
                            w_need_d  = '0;
                        end else if (w_accept) begin
                            w_state_d = StGap;
                            w_need_d  = NEED_STRIDE_M1;
                        end else begin
                            w_state_d = StGap;
                            w_need_d  = NEED_STRIDE;
                        end
                    end
                end
                default: begin
                    w_state_d = StFill;
                    w_need_d  = NEED_FULL;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StFill;
            r_need  <= NEED_FULL;
            r_seq   <= '0;
        end else begin
            r_state <= w_state_d;
            r_need  <= w_need_d;
            r_seq   <= w_seq_d;
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = w_out_valid;
    assign o_shift_en  = w_accept && !i_flush;
    assign o_out_seq   = r_seq;

endmodule

// File: rtl/median_window_10.sv
// Sliding 10-sample window collector feeding the median sort network;
// win_0 is the oldest sample, win_9 the newest.
module median_window_10
    import median_pkg::*;
#(
    parameter int unsigned STRIDE = 1
) (
    input  logic  i_clk,
    input  logic  i_rst_n,
    input  logic  i_flush,
    input  logic  i_in_valid,
    input  data_t i_in_data,
    output logic  o_in_ready,
    output logic  o_out_valid,
    input  logic  i_out_ready,
    output data_t o_win_0,
    output data_t o_win_1,
    output data_t o_win_2,
    output data_t o_win_3,
    output data_t o_win_4,
    output data_t o_win_5,
    output data_t o_win_6,
    output data_t o_win_7,
    output data_t o_win_8,
    output data_t o_win_9,
    output seq_t  o_out_seq
);

    if ((STRIDE < 1) || (STRIDE > MEDIAN_WIN)) begin : g_bad_stride
        $error("median_window_10: STRIDE must be in 1..10");
    end

    logic  w_shift_en;
    data_t r_win [MEDIAN_WIN];

    median_window_ctrl #(
        .STRIDE(STRIDE)
    ) u_ctrl (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_flush    (i_flush),
        .i_in_valid (i_in_valid),
        .i_out_ready(i_out_ready),
        .o_in_ready (o_in_ready),
        .o_out_valid(o_out_valid),
        .o_shift_en (w_shift_en),
        .o_out_seq  (o_out_seq)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < MEDIAN_WIN; i++) r_win[i] <= '0;
        end else if (i_flush) begin
            for (int unsigned i = 0; i < MEDIAN_WIN; i++) r_win[i] <= '0;
        end else if (w_shift_en) begin
            for (int unsigned i = 0; i < MEDIAN_WIN - 1; i++) r_win[i] <= r_win[i+1];
            r_win[MEDIAN_WIN-1] <= i_in_data;
        end
    end

    assign o_win_0 = r_win[0];
    assign o_win_1 = r_win[1];
    assign o_win_2 = r_win[2];
    assign o_win_3 = r_win[3];
    assign o_win_4 = r_win[4];
    assign o_win_5 = r_win[5];
    assign o_win_6 = r_win[6];
    assign o_win_7 = r_win[7];
    assign o_win_8 = r_win[8];
    assign o_win_9 = r_win[9];

endmodule

// File: tb/tb_median_window_10.sv
// Bench for median_window_10: directed scenarios plus a randomized run on a
// STRIDE=1 and a STRIDE=3 instance against a sample-queue reference model.
module tb_median_window_10;
    import median_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  flush;
    logic  in_valid;
    data_t in_data;
    logic  out_ready;

    logic  a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    data_t a_win [10];
    data_t b_win [10];
    seq_t  a_seq, b_seq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    median_window_10 #(.STRIDE(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
        .i_in_data(in_data), .o_in_ready(a_in_ready), .o_out_valid(a_out_valid),
        .i_out_ready(out_ready),
        .o_win_0(a_win[0]), .o_win_1(a_win[1]), .o_win_2(a_win[2]), .o_win_3(a_win[3]),
        .o_win_4(a_win[4]), .o_win_5(a_win[5]), .o_win_6(a_win[6]), .o_win_7(a_win[7]),
        .o_win_8(a_win[8]), .o_win_9(a_win[9]), .o_out_seq(a_seq)
    );

    median_window_10 #(.STRIDE(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .i_in_valid(in_valid),
        .i_in_data(in_data), .o_in_ready(b_in_ready), .o_out_valid(b_out_valid),
        .i_out_ready(out_ready),
        .o_win_0(b_win[0]), .o_win_1(b_win[1]), .o_win_2(b_win[2]), .o_win_3(b_win[3]),
        .o_win_4(b_win[4]), .o_win_5(b_win[5]), .o_win_6(b_win[6]), .o_win_7(b_win[7]),
        .o_win_8(b_win[8]), .o_win_9(b_win[9]), .o_out_seq(b_seq)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        in_valid = 1'b0;
        next_cycle();
        flush = 1'b0;
    endtask

    task automatic feed(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1;
            in_data  = data_t'(first + i);
            next_cycle();
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %0b want 0", a_out_valid);
        end
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %0b want 1", a_in_ready);
        end
        n_tests++;
        if (a_seq !== 16'd0) begin
            n_fail++; $display("FAIL reset_seq got %0d want 0", a_seq);
        end
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (a_win[k] !== 32'd0) begin
                n_fail++; $display("FAIL reset_lane%0d got %0h want 0", k, a_win[k]);
            end
        end
        n_tests++;
        if (b_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid_b got %0b want 0", b_out_valid);
        end
        next_cycle();
    endtask

    task automatic test_fill_slide();
        do_flush();
        out_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            in_valid = 1'b1;
            in_data  = data_t'(i);
            @(negedge clk);
            n_tests++;
            if (a_out_valid !== (i > 10)) begin
                n_fail++; $display("FAIL fill_valid@%0d got %0b want %0b", i, a_out_valid, i > 10);
            end
            n_tests++;
            if (a_in_ready !== 1'b1) begin
                n_fail++; $display("FAIL fill_in_ready@%0d got %0b want 1", i, a_in_ready);
            end
            if (i > 10) begin
                n_tests++;
                if (a_seq !== seq_t'(i - 11)) begin
                    n_fail++; $display("FAIL fill_seq@%0d got %0d want %0d", i, a_seq, i - 11);
                end
                for (int k = 0; k < 10; k++) begin
                    n_tests++;
                    if (a_win[k] !== data_t'(i - 10 + k)) begin
                        n_fail++;
                        $display("FAIL fill_lane%0d@%0d got %0d want %0d", k, i, a_win[k], i - 10 + k);
                    end
                end
            end
            next_cycle();
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b1 || a_seq !== 16'd2) begin
            n_fail++; $display("FAIL slide_last got v=%0b seq=%0d want v=1 seq=2", a_out_valid, a_seq);
        end
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (a_win[k] !== data_t'(3 + k)) begin
                n_fail++; $display("FAIL slide_lane%0d got %0d want %0d", k, a_win[k], 3 + k);
            end
        end
        next_cycle();
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL slide_drain got %0b want 0", a_out_valid);
        end
        next_cycle();
    endtask

    task automatic test_backpressure();
        do_flush();
        out_ready = 1'b1;
        feed(1, 10);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_tests++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || a_seq !== 16'd0) begin
                n_fail++;
                $display("FAIL bp_hold@%0d got rdy=%0b v=%0b seq=%0d want rdy=0 v=1 seq=0",
                         c, a_in_ready, a_out_valid, a_seq);
            end
            for (int k = 0; k < 10; k++) begin
                n_tests++;
                if (a_win[k] !== data_t'(1 + k)) begin
                    n_fail++; $display("FAIL bp_lane%0d@%0d got %0d want %0d", k, c, a_win[k], 1 + k);
                end
            end
            next_cycle();
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready got %0b want 1", a_in_ready);
        end
        next_cycle();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b1 || a_seq !== 16'd1) begin
            n_fail++; $display("FAIL bp_next got v=%0b seq=%0d want v=1 seq=1", a_out_valid, a_seq);
        end
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (a_win[k] !== data_t'(2 + k)) begin
                n_fail++; $display("FAIL bp_next_lane%0d got %0d want %0d", k, a_win[k], 2 + k);
            end
        end
        next_cycle();
    endtask

    // STRIDE=3 instance: a window is due once 10 + 3*(windows taken) samples are in.
    task automatic test_stride3();
        int acc;
        int nwin;
        int seen;
        logic exp_v;
        do_flush();
        out_ready = 1'b1;
        acc = 0; nwin = 0; seen = 0;
        for (int i = 1; i <= 20; i++) begin
            in_valid = (i <= 16);
            in_data  = data_t'(i);
            @(negedge clk);
            exp_v = (acc >= 10 + 3 * nwin);
            n_tests++;
            if (b_out_valid !== exp_v) begin
                n_fail++; $display("FAIL s3_valid@%0d got %0b want %0b", i, b_out_valid, exp_v);
            end
            if (b_out_valid === 1'b1) begin
                seen++;
                n_tests++;
                if (b_seq !== seq_t'(nwin)) begin
                    n_fail++; $display("FAIL s3_seq@%0d got %0d want %0d", i, b_seq, nwin);
                end
                for (int k = 0; k < 10; k++) begin
                    n_tests++;
                    if (b_win[k] !== data_t'(1 + 3 * nwin + k)) begin
                        n_fail++;
                        $display("FAIL s3_lane%0d@%0d got %0d want %0d",
                                 k, i, b_win[k], 1 + 3 * nwin + k);
                    end
                end
            end
            if (exp_v) nwin++;
            if (i <= 16) acc++;
            next_cycle();
        end
        in_valid = 1'b0;
        n_tests++;
        if (seen != 3) begin
            n_fail++; $display("FAIL s3_window_count got %0d want 3", seen);
        end
    endtask

    task automatic test_flush_mid_fill();
        do_flush();
        out_ready = 1'b1;
        feed(1, 6);
        do_flush();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = data_t'(100 + i);
            @(negedge clk);
            n_tests++;
            if (a_out_valid !== 1'b0) begin
                n_fail++; $display("FAIL fmf_early_valid@%0d got %0b want 0", i, a_out_valid);
            end
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b1 || a_seq !== 16'd0) begin
            n_fail++; $display("FAIL fmf_window got v=%0b seq=%0d want v=1 seq=0", a_out_valid, a_seq);
        end
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (a_win[k] !== data_t'(100 + k)) begin
                n_fail++; $display("FAIL fmf_lane%0d got %0d want %0d", k, a_win[k], 100 + k);
            end
        end
        next_cycle();
    endtask

    // Runs straight after test_flush_mid_fill: window 100..109 is presented.
    task automatic test_flush_handshake();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'd110;
        next_cycle();
        flush   = 1'b1;
        in_data = 32'd111;
        next_cycle();
        flush     = 1'b0;
        in_valid  = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b0 || a_seq !== 16'd0) begin
            n_fail++; $display("FAIL fhs_after got v=%0b seq=%0d want v=0 seq=0", a_out_valid, a_seq);
        end
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (a_win[k] !== 32'd0) begin
                n_fail++; $display("FAIL fhs_lane%0d got %0d want 0", k, a_win[k]);
            end
        end
        next_cycle();
        feed(200, 10);
        out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b1 || a_seq !== 16'd0 || a_win[0] !== 32'd200 || a_win[9] !== 32'd209)
        begin
            n_fail++;
            $display("FAIL fhs_refill got v=%0b seq=%0d w0=%0d w9=%0d want v=1 seq=0 w0=200 w9=209",
                     a_out_valid, a_seq, a_win[0], a_win[9]);
        end
        next_cycle();
    endtask

    task automatic test_async_reset();
        do_flush();
        out_ready = 1'b0;
        feed(50, 10);
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b1) begin
            n_fail++; $display("FAIL ar_pre_valid got %0b want 1", a_out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (a_out_valid !== 1'b0 || a_seq !== 16'd0 || a_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_immediate got v=%0b seq=%0d rdy=%0b want v=0 seq=0 rdy=1",
                     a_out_valid, a_seq, a_in_ready);
        end
        for (int k = 0; k < 10; k++) begin
            n_tests++;
            if (a_win[k] !== 32'd0) begin
                n_fail++; $display("FAIL ar_lane%0d got %0d want 0", k, a_win[k]);
            end
        end
        next_cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = data_t'(60 + i);
            @(negedge clk);
            n_tests++;
            if (a_out_valid !== 1'b0) begin
                n_fail++; $display("FAIL ar_refill_valid@%0d got %0b want 0", i, a_out_valid);
            end
            next_cycle();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (a_out_valid !== 1'b1 || a_win[0] !== 32'd60 || a_win[9] !== 32'd69) begin
            n_fail++;
            $display("FAIL ar_window got v=%0b w0=%0d w9=%0d want v=1 w0=60 w9=69",
                     a_out_valid, a_win[0], a_win[9]);
        end
        next_cycle();
    endtask

    // Both instances against a queue of every sample accepted since the last flush.
    task automatic test_random();
        data_t mq0[$];
        data_t mq1[$];
        int    acc [2];
        int    hk [2];
        int    strd [2];
        logic  ov, ir, exp_v;
        seq_t  sq;
        data_t w [10];
        data_t exp_d;
        strd[0] = 1; strd[1] = 3;
        for (int c = 0; c < 3000; c++) begin
            flush     = (c == 0) || ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            in_data   = $urandom;
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (d == 0) begin
                    ov = a_out_valid; ir = a_in_ready; sq = a_seq; w = a_win;
                end else begin
                    ov = b_out_valid; ir = b_in_ready; sq = b_seq; w = b_win;
                end
                if (c != 0) begin
                    exp_v = (acc[d] >= 10 + hk[d] * strd[d]);
                    n_tests++;
                    if (ov !== exp_v) begin
                        n_fail++; $display("FAIL rnd_valid d%0d@%0d got %0b want %0b", d, c, ov, exp_v);
                    end
                    n_tests++;
                    if (ir !== (!exp_v || out_ready)) begin
                        n_fail++;
                        $display("FAIL rnd_in_ready d%0d@%0d got %0b want %0b",
                                 d, c, ir, !exp_v || out_ready);
                    end
                    if (exp_v) begin
                        n_tests++;
                        if (sq !== seq_t'(hk[d])) begin
                            n_fail++; $display("FAIL rnd_seq d%0d@%0d got %0d want %0d", d, c, sq, hk[d]);
                        end
                        for (int k = 0; k < 10; k++) begin
                            exp_d = (d == 0) ? mq0[hk[d] * strd[d] + k] : mq1[hk[d] * strd[d] + k];
                            n_tests++;
                            if (w[k] !== exp_d) begin
                                n_fail++;
                                $display("FAIL rnd_lane%0d d%0d@%0d got %0h want %0h",
                                         k, d, c, w[k], exp_d);
                            end
                        end
                    end
                end else begin
                    exp_v = 1'b0;
                end
                if (flush) begin
                    acc[d] = 0; hk[d] = 0;
                    if (d == 0) mq0.delete(); else mq1.delete();
                end else begin
                    if (in_valid && (!exp_v || out_ready)) begin
                        acc[d]++;
                        if (d == 0) mq0.push_back(in_data); else mq1.push_back(in_data);
                    end
                    if (exp_v && out_ready) hk[d]++;
                end
            end
            next_cycle();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_seq_wrap();
        int h;
        do_flush();
        out_ready = 1'b1;
        h = 0;
        for (int c = 0; c < 70000 && h <= 65537; c++) begin
            in_valid = 1'b1;
            in_data  = data_t'(c + 1);
            @(negedge clk);
            if (a_out_valid === 1'b1) begin
                if (h >= 65535) begin
                    n_tests++;
                    if (a_seq !== seq_t'(h) || a_win[0] !== data_t'(h + 1)) begin
                        n_fail++;
                        $display("FAIL wrap@%0d got seq=%0d w0=%0d want seq=%0d w0=%0d",
                                 h, a_seq, a_win[0], h % 65536, h + 1);
                    end
                end
                h++;
            end
            next_cycle();
        end
        in_valid = 1'b0;
        n_tests++;
        if (h <= 65537) begin
            n_fail++; $display("FAIL wrap_timeout got %0d windows want 65538", h);
        end
    endtask

    initial begin
        test_reset();
        test_fill_slide();
        test_backpressure();
        test_stride3();
        test_flush_mid_fill();
        test_flush_handshake();
        test_async_reset();
        test_random();
        test_seq_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
